// File: rtl/qr_tx_pkg.sv
// Shared types and constants for the quarter-rate TX word scheduler.
package qr_tx_pkg;

  typedef enum logic [1:0] {
    StOff   = 2'd0,
    StIdle  = 2'd1,
    StTrain = 2'd2,
    StData  = 2'd3
  } qr_tx_state_e;

  localparam int unsigned NIB_W = 4;

  // Nyquist clock pattern used for training when PRBS is not built in.
  localparam logic [NIB_W-1:0] NYQ_NIB = 4'b1010;

  // PRBS7 = x^7 + x^6 + 1.
  localparam logic [6:0]  PRBS7_SEED   = 7'h7F;
  localparam int unsigned PRBS7_TAP_HI = 6;
  localparam int unsigned PRBS7_TAP_LO = 5;

  // Advance PRBS7 by one nibble. Returns {nibble, next_state}; the bit leaving
  // the top of the register is the output, so the first bit lands in nibble[3].
  function automatic logic [NIB_W+6:0] prbs7_step4(input logic [6:0] seed);
    logic [6:0]       s;
    logic [NIB_W-1:0] nib;
    s   = seed;
    nib = '0;
    for (int i = 0; i < NIB_W; i++) begin
      nib[NIB_W-1-i] = s[6];
      s = {s[5:0], s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO]};
    end
    return {nib, s};
  endfunction

endpackage

// File: rtl/qr_tx_word_fifo.sv
// Word buffer between the upstream valid/ready port and the nibble slicer.
// Synchronous FIFO with a synchronous flush; pointers carry one wrap bit.
module qr_tx_word_fifo #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [WORD_W-1:0] wdata,
  input  logic              pop,
  output logic [WORD_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]       wptr_q, rptr_q;
  logic [WORD_W-1:0] mem_q [DEPTH];

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = mem_q[rptr_q[AW-1:0]];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

  // Read/write pointers; flush discards everything held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) wptr_q <= wptr_q + 1'b1;
      if (pop && !empty) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/qr_tx_word_sched.sv
// Quarter-rate word scheduler: buffers words, slices them into nibbles for the
// 4:1 mux and arbitrates idle fill / training / payload.
// Build option: define QR_TX_PRBS_EN for a PRBS7 training pattern instead of 1010.
module qr_tx_word_sched
  import qr_tx_pkg::*;
#(
  parameter int unsigned      WORD_W     = 16,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter int unsigned      TRAIN_LEN  = 127,
  parameter logic [NIB_W-1:0] IDLE_NIB   = 4'b0000
) (
  input  logic              clk_Q,
  input  logic              rst_n,
  input  logic              en,
  input  logic              train_req,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic [NIB_W-1:0]  din,
  output logic              clk_dmy_gating,
  output logic [1:0]        state_o,
  output logic              train_done
);

  localparam int unsigned NIBS       = WORD_W / NIB_W;
  localparam int unsigned CW         = $clog2(NIBS);
  localparam logic [9:0]  TRAIN_LAST = 10'(TRAIN_LEN);

  qr_tx_state_e      state_q, state_d;
  logic [NIB_W-1:0]  din_q, din_d;
  logic              gate_q, gate_d;
  logic              done_q, done_d;
  logic              pend_q, pend_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     nib_q, nib_d;
  logic [9:0]        tcnt_q, tcnt_d;

  logic              push, pop, full, empty;
  logic [WORD_W-1:0] head;

`ifdef QR_TX_PRBS_EN
  logic [6:0]       lfsr_q, lfsr_d;
  logic [NIB_W+6:0] prbs_res;
`endif

  assign s_ready        = (state_q != StOff) && !full;
  assign push           = s_valid && s_ready;
  assign din            = din_q;
  assign clk_dmy_gating = gate_q;
  assign state_o        = state_q;
  assign train_done     = done_q;

  qr_tx_word_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_Q),
    .rst_n (rst_n),
    .flush (!en),
    .push  (push),
    .wdata (s_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d  = state_q;
    din_d    = din_q;
    gate_d   = gate_q;
    done_d   = 1'b0;
    pend_d   = pend_q;
    shreg_d  = shreg_q;
    nib_d    = nib_q;
    tcnt_d   = tcnt_q;
    pop      = 1'b0;
`ifdef QR_TX_PRBS_EN
    lfsr_d   = lfsr_q;
    prbs_res = '0;
`endif
    if (!en) begin
      state_d = StOff;
      din_d   = IDLE_NIB;
      gate_d  = 1'b1;
      pend_d  = 1'b0;
      nib_d   = '0;
      shreg_d = '0;
    end else begin
      unique case (state_q)
        StOff: begin
          state_d = StIdle;
          din_d   = IDLE_NIB;
          gate_d  = 1'b1;
        end
        StIdle: begin
          if (train_req || pend_q) begin
            state_d = StTrain;
            gate_d  = 1'b0;
            pend_d  = 1'b0;
            tcnt_d  = 10'd1;
`ifdef QR_TX_PRBS_EN
            prbs_res = prbs7_step4(PRBS7_SEED);
            din_d    = prbs_res[NIB_W+6:7];
            lfsr_d   = prbs_res[6:0];
`else
            din_d    = NYQ_NIB;
`endif
          end else if (!empty) begin
            state_d = StData;
            gate_d  = 1'b0;
            pop     = 1'b1;
            din_d   = head[WORD_W-1 -: NIB_W];
            shreg_d = head << NIB_W;
            nib_d   = CW'(NIBS - 1);
          end
        end
        StTrain: begin
          if (tcnt_q >= TRAIN_LAST) begin
            state_d = StIdle;
            din_d   = IDLE_NIB;
            gate_d  = 1'b1;
            done_d  = 1'b1;
          end else begin
            tcnt_d = (tcnt_q == 10'h3FF) ? tcnt_q : tcnt_q + 10'd1;
`ifdef QR_TX_PRBS_EN
            prbs_res = prbs7_step4(lfsr_q);
            din_d    = prbs_res[NIB_W+6:7];
            lfsr_d   = prbs_res[6:0];
`else
            din_d    = NYQ_NIB;
`endif
          end
        end
        StData: begin
          if (train_req) pend_d = 1'b1;
          if (nib_q != '0) begin
            din_d   = shreg_q[WORD_W-1 -: NIB_W];
            shreg_d = shreg_q << NIB_W;
            nib_d   = nib_q - 1'b1;
          end else if (!empty && !pend_q && !train_req) begin
            // Back-to-back word: no idle bubble between words.
            pop     = 1'b1;
            din_d   = head[WORD_W-1 -: NIB_W];
            shreg_d = head << NIB_W;
            nib_d   = CW'(NIBS - 1);
          end else begin
            state_d = StIdle;
            din_d   = IDLE_NIB;
            gate_d  = 1'b1;
          end
        end
        default: state_d = StOff;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_Q or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOff;
      din_q   <= IDLE_NIB;
      gate_q  <= 1'b1;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      shreg_q <= '0;
      nib_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      shreg_q <= shreg_d;
      nib_q   <= nib_d;
      tcnt_q  <= tcnt_d;
    end
  end

`ifdef QR_TX_PRBS_EN
  // Training LFSR, reseeded on every TRAIN entry.
  always_ff @(posedge clk_Q or negedge rst_n) begin
    if (!rst_n) lfsr_q <= PRBS7_SEED;
    else        lfsr_q <= lfsr_d;
  end
`endif

endmodule

// File: tb/tb_qr_tx_word_sched.sv
// Bench for qr_tx_word_sched: directed scenarios plus random traffic, all
// checked each cycle against a queue-based behavioural model.
module tb_qr_tx_word_sched;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned TRAIN_LEN = 127;
  localparam logic [3:0]  IDLE_NIB  = 4'h0;

  logic        clk_Q = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        train_req = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready;
  logic [3:0]  din;
  logic        clk_dmy_gating;
  logic [1:0]  state_o;
  logic        train_done;

  qr_tx_word_sched #(
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (DEPTH),
    .TRAIN_LEN  (TRAIN_LEN),
    .IDLE_NIB   (IDLE_NIB)
  ) dut (
    .clk_Q          (clk_Q),
    .rst_n          (rst_n),
    .en             (en),
    .train_req      (train_req),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .din            (din),
    .clk_dmy_gating (clk_dmy_gating),
    .state_o        (state_o),
    .train_done     (train_done)
  );

  always #5 clk_Q = ~clk_Q;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: words waiting, nibbles still to send of the current word.
  int          m_state;
  logic [15:0] wq[$];
  logic [3:0]  nq[$];
  logic [3:0]  m_din;
  bit          m_gate, m_done, m_pend;
  int          m_tcnt;
  logic [6:0]  m_lfsr;

  function automatic void m_reset();
    m_state = 0;
    wq.delete();
    nq.delete();
    m_din  = IDLE_NIB;
    m_gate = 1'b1;
    m_done = 1'b0;
    m_pend = 1'b0;
    m_tcnt = 0;
    m_lfsr = 7'h7F;
  endfunction

  function automatic logic [3:0] m_pattern(input bit fresh);
`ifdef QR_TX_PRBS_EN
    logic [3:0] n;
    logic       b;
    if (fresh) m_lfsr = 7'h7F;
    for (int i = 3; i >= 0; i--) begin
      b      = m_lfsr[6];
      n[i]   = b;
      m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    end
    return n;
`else
    if (fresh) m_lfsr = 7'h7F;
    return 4'b1010;
`endif
  endfunction

  function automatic void m_load();
    logic [15:0] w;
    w = wq.pop_front();
    nq.delete();
    for (int i = 0; i < 4; i++) nq.push_back(w[15-4*i -: 4]);
    m_din   = nq.pop_front();
    m_state = 3;
    m_gate  = 1'b0;
  endfunction

  function automatic void m_to_idle();
    m_state = 1;
    m_din   = IDLE_NIB;
    m_gate  = 1'b1;
  endfunction

  function automatic void m_step(input bit e, input bit t, input bit v, input logic [15:0] d);
    bit rdy, psh, old_pend;
    rdy = (m_state != 0) && (wq.size() < DEPTH);
    psh = v && rdy;
    if (!e) begin
      m_reset();
      return;
    end
    m_done   = 1'b0;
    old_pend = m_pend;
    case (m_state)
      0: m_to_idle();
      1: begin
        if (t || m_pend) begin
          m_state = 2;
          m_gate  = 1'b0;
          m_pend  = 1'b0;
          m_tcnt  = 1;
          m_din   = m_pattern(1'b1);
        end else if (wq.size() > 0) begin
          m_load();
        end
      end
      2: begin
        if (m_tcnt == TRAIN_LEN) begin
          m_to_idle();
          m_done = 1'b1;
        end else begin
          m_tcnt++;
          m_din = m_pattern(1'b0);
        end
      end
      default: begin
        if (t) m_pend = 1'b1;
        if (nq.size() > 0)                         m_din = nq.pop_front();
        else if (wq.size() > 0 && !old_pend && !t) m_load();
        else                                       m_to_idle();
      end
    endcase
    if (psh) wq.push_back(d);
  endfunction

  task automatic compare_all();
    check("din",        32'(din),            32'(m_din));
    check("gating",     32'(clk_dmy_gating), 32'(m_gate));
    check("state",      32'(state_o),        32'(m_state));
    check("train_done", 32'(train_done),     32'(m_done));
    check("s_ready",    32'(s_ready),
          32'((m_state != 0) && (wq.size() < DEPTH)));
  endtask

  // One clock: drive inputs, step model on the edge, compare 1 time unit later.
  task automatic cycle(input bit e, input bit t, input bit v, input logic [15:0] d);
    en        = e;
    train_req = t;
    s_valid   = v;
    s_data    = d;
    @(posedge clk_Q);
    m_step(e, t, v, d);
    #1;
    compare_all();
  endtask

  logic [3:0] exp_a5c3 [5];
  int         done_cnt;
  int         saw_full;

  initial begin
    m_reset();
    exp_a5c3 = '{4'hA, 4'h5, 4'hC, 4'h3, 4'h0};

    // Reset values.
    #12;
    compare_all();
    rst_n = 1'b1;

    // Single word A5C3: first nibble after edge k+1.
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b1, 16'hA5C3);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      check("a5c3_nib", 32'(din), 32'(exp_a5c3[i]));
    end

    // Back-to-back words with s_valid held; ready must drop while full.
    saw_full = 0;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 16'($urandom));
      if (!s_ready) saw_full++;
    end
    for (int i = 0; i < 24; i++) cycle(1'b1, 1'b0, 1'b0, '0);
    check("saw_full", 32'(saw_full > 0), 32'd1);

    // Training request mid-word.
    cycle(1'b1, 1'b0, 1'b1, 16'h1234);
    cycle(1'b1, 1'b0, 1'b1, 16'h5678);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    done_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      if (train_done) done_cnt++;
    end
    check("train_done_cnt", 32'(done_cnt), 32'd1);

    // Disable with words queued; re-enable must not emit stale data.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 16'hBEEF);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check("off_din", 32'(din), 32'(IDLE_NIB));
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, '0);
    check("stale_din", 32'(din), 32'(IDLE_NIB));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(63) != 0, $urandom_range(99) == 0,
            $urandom_range(1) == 1, 16'($urandom));
    end

    // Asynchronous reset in the middle of TRAIN.
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, 16'($urandom));
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    compare_all();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
